// File: rtl/digit_scan_mux.sv
// Time-multiplexed driver for a 4-digit 7-segment display with a shadow register
// that is committed only at frame boundaries, plus optional leading-zero blanking.
module digit_scan_mux #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        blank_lz,
  output logic        S0,
  output logic        S1,
  output logic        S2,
  output logic        S3,
  output logic [3:0]  an,
  output logic        blank,
  output logic        pending
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   shadow_reg;
  logic [15:0]   disp_reg;
  logic          pending_reg;
  logic [3:0]    an_reg;
  logic          blank_reg;
  logic [3:0]    nib_reg;

  logic          tick;
  logic          commit;
  logic [3:0]    lz_blank;
  logic          show;
  logic [3:0]    an_next;
  logic          blank_next;
  logic [3:0]    nib_next;

  assign tick   = en && (cnt_reg == CNT_MAX);
  assign commit = tick && (idx_reg == 2'd3) && pending_reg;

  // Prescaler and digit index; both hold while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      idx_reg <= 2'd0;
    end else if (tick) begin
      cnt_reg <= '0;
      idx_reg <= idx_reg + 2'd1;
    end else if (en) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // A load coinciding with a commit still leaves the new value pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg  <= 16'h0000;
      disp_reg    <= 16'h0000;
      pending_reg <= 1'b0;
    end else begin
      if (commit) begin
        disp_reg <= shadow_reg;
      end
      if (load) begin
        shadow_reg  <= data_in;
        pending_reg <= 1'b1;
      end else if (commit) begin
        pending_reg <= 1'b0;
      end
    end
  end

  // Digit k is a leading zero when it and every more significant nibble are zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = blank_lz && (disp_reg[15:4*gi] == '0);
      end
    end
  endgenerate

  always_comb begin
    show       = en && !lz_blank[idx_reg];
    an_next    = 4'b1111;
    blank_next = 1'b1;
    nib_next   = 4'b0000;
    if (show) begin
      an_next    = ~(4'b0001 << idx_reg);
      blank_next = 1'b0;
      nib_next   = disp_reg[idx_reg*4 +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg    <= 4'b1111;
      blank_reg <= 1'b1;
      nib_reg   <= 4'b0000;
    end else begin
      an_reg    <= an_next;
      blank_reg <= blank_next;
      nib_reg   <= nib_next;
    end
  end

  assign an      = an_reg;
  assign blank   = blank_reg;
  assign S0      = nib_reg[0];
  assign S1      = nib_reg[1];
  assign S2      = nib_reg[2];
  assign S3      = nib_reg[3];
  assign pending = pending_reg;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench: a frame-position reference model queues the expected outputs
// for every edge; a negedge monitor pops and compares them against the DUT.
module tb_digit_scan_mux;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] data_in;
  logic        blank_lz;
  logic        S0, S1, S2, S3;
  logic [3:0]  an;
  logic        blank;
  logic        pending;

  digit_scan_mux #(.DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .load    (load),
    .data_in (data_in),
    .blank_lz(blank_lz),
    .S0      (S0),
    .S1      (S1),
    .S2      (S2),
    .S3      (S3),
    .an      (an),
    .blank   (blank),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic       blank;
    logic [3:0] s;
    logic       pending;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: position within the frame, 0..FRAME-1.
  int m_pos     = 0;
  int m_shadow  = 0;
  int m_disp    = 0;
  int m_pending = 0;

  function automatic bit digit_blanked(int k, int disp, bit blz);
    return (k > 0) && blz && ((disp >> (4 * k)) == 0);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   k;
    bit   frame_end;
    if (!rst_n) begin
      m_pos = 0; m_shadow = 0; m_disp = 0; m_pending = 0;
      e.an = 4'b1111; e.blank = 1'b1; e.s = 4'h0; e.pending = 1'b0;
    end else begin
      k = m_pos / DIV;
      if (en && !digit_blanked(k, m_disp, blank_lz)) begin
        e.an    = 4'(15 - (1 << k));
        e.blank = 1'b0;
        e.s     = 4'((m_disp >> (4 * k)) & 15);
      end else begin
        e.an = 4'b1111; e.blank = 1'b1; e.s = 4'h0;
      end
      frame_end = en && (m_pos == FRAME - 1);
      if (frame_end && m_pending != 0) begin
        m_disp = m_shadow;
        m_pending = 0;
      end
      if (load) begin
        m_shadow  = int'(data_in);
        m_pending = 1;
      end
      if (en) m_pos = (m_pos + 1) % FRAME;
      e.pending = (m_pending != 0);
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] s;
    if (q.size() > 0) begin
      e = q.pop_front();
      s = {S3, S2, S1, S0};
      checks++;
      if (an !== e.an) begin
        errors++;
        $display("FAIL an t=%0t got %b want %b", $time, an, e.an);
      end
      checks++;
      if (blank !== e.blank) begin
        errors++;
        $display("FAIL blank t=%0t got %b want %b", $time, blank, e.blank);
      end
      checks++;
      if (s !== e.s) begin
        errors++;
        $display("FAIL nibble t=%0t got %h want %h", $time, s, e.s);
      end
      checks++;
      if (pending !== e.pending) begin
        errors++;
        $display("FAIL pending t=%0t got %b want %b", $time, pending, e.pending);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL an_onehot t=%0t got %b want at most one low", $time, an);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  task automatic do_load(input logic [15:0] d);
    @(negedge clk);
    load    = 1'b1;
    data_in = d;
    $display("load data=%h pos=%0d pending=%0d t=%0t", d, m_pos, m_pending, $time);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Advance (bounded) until the reference model reaches a given frame position.
  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    @(negedge clk);
    load = 1'b0;
    while (m_pos != pos && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_pos != pos) begin
      errors++;
      $display("FAIL wait_pos got %0d want %0d", m_pos, pos);
    end
  endtask

  task automatic check_now(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    logic [15:0] mask;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; data_in = 16'h0000; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic scan after a load of 1234.
    en = 1'b1;
    do_load(16'h1234);
    idle(6 * FRAME);

    // Load while digit 1 is active; commit waits for the frame boundary.
    wait_pos(DIV);
    load = 1'b1; data_in = 16'hABCD;
    $display("load data=%h pos=%0d t=%0t", data_in, m_pos, $time);
    idle(2 * FRAME);

    // Leading-zero suppression.
    blank_lz = 1'b1;
    do_load(16'h0005);
    idle(2 * FRAME);
    do_load(16'h0000);
    idle(2 * FRAME);
    do_load(16'h0300);
    idle(2 * FRAME);
    blank_lz = 1'b0;

    // Pause mid-slot and resume.
    wait_pos(2 * DIV + 1);
    en = 1'b0;
    idle(10);
    en = 1'b1;
    idle(FRAME);

    // Load exactly on the commit edge.
    do_load(16'h1111);
    wait_pos(FRAME - 1);
    load = 1'b1; data_in = 16'h2222;
    $display("load data=%h on commit edge t=%0t", data_in, $time);
    idle(3 * FRAME);

    // Asynchronous reset between edges with a pending load.
    do_load(16'h7777);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check_now("rst_an", an, 4'b1111);
    check_now("rst_blank", {3'b000, blank}, 4'h1);
    check_now("rst_nibble", {S3, S2, S1, S0}, 4'h0);
    check_now("rst_pending", {3'b000, pending}, 4'h0);
    idle(2);
    #2 rst_n = 1'b1;
    idle(2 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en   = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 4))
        0: mask = 16'hFFFF;
        1: mask = 16'h0FFF;
        2: mask = 16'h00FF;
        3: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      data_in = 16'($urandom) & mask;
      if (load) $display("load data=%h pos=%0d t=%0t", data_in, m_pos, $time);
      if (i % 64 == 0) blank_lz = 1'($urandom_range(0, 1));
    end
    load = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
